// File: rtl/wb_pkg.sv
// Shared write-back definitions: default widths, the request record and the
// round-robin pointer advance helper.
package wb_pkg;

   localparam int XLEN     = 32;
   localparam int AW       = 5;
   localparam int WB_CNT_W = 16;

   typedef struct packed {
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;
   } wb_req_t;

   // Next priority position after index idx, wrapping at n.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid bit at or after ptr_i, wrapping.
// Returns a one-hot grant, its encoded index and whether anything was valid.
module rr_pick #(
   parameter int N = 3,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  valid_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic [PW-1:0] idx_o,
   output logic          any_o
);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   logic [PW-1:0]  pos;
   logic [PW:0]    sum;

   // Rotating a doubled copy puts the ptr position at bit 0.
   assign dbl = {valid_i, valid_i};
   assign rot = N'(dbl >> ptr_i);

   always_comb begin
      pos   = '0;
      any_o = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) begin
            pos   = PW'(k);
            any_o = 1'b1;
         end
      end
      sum = {1'b0, ptr_i} + {1'b0, pos};
      if (sum >= (PW + 1)'(N)) begin
         sum = sum - (PW + 1)'(N);
      end
      idx_o   = sum[PW-1:0];
      grant_o = any_o ? (N'(1) << idx_o) : '0;
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter for the register file write port with a registered write stage.
// Define WB_PORT_ARBITER_X0_DROP_EN to swallow writes to register 0 after the handshake.
module wb_port_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int XLEN    = wb_pkg::XLEN,
   parameter int AW      = wb_pkg::AW
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          stall,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*AW-1:0]         req_addr,
   input  logic [NUM_REQ*XLEN-1:0]       req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          wr_en,
   output logic [AW-1:0]                 wr_addr,
   output logic [XLEN-1:0]               wr_data,
   output logic [wb_pkg::WB_CNT_W-1:0]   wr_count
);

   import wb_pkg::*;

   localparam int PW = $clog2(NUM_REQ);

   typedef struct packed {
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;
   } req_t;

   req_t                req_arr [NUM_REQ];
   req_t                win_req;
   logic [NUM_REQ-1:0]  grant;
   logic [PW-1:0]       win_idx;
   logic                win_any;
   logic                open;
   logic                xfer;
   logic                issue;

   logic [PW-1:0]       ptr_q,   ptr_d;
   logic                wr_en_q, wr_en_d;
   logic [AW-1:0]       wr_addr_q, wr_addr_d;
   logic [XLEN-1:0]     wr_data_q, wr_data_d;
   logic [WB_CNT_W-1:0] cnt_q,   cnt_d;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign req_arr[gi] = {req_addr[gi*AW +: AW], req_data[gi*XLEN +: XLEN]};
      end
   endgenerate

   rr_pick #(.N(NUM_REQ)) u_pick (
      .valid_i (req_valid),
      .ptr_i   (ptr_q),
      .grant_o (grant),
      .idx_o   (win_idx),
      .any_o   (win_any)
   );

   // Grants are withheld during stall and while reset is asserted.
   assign open      = reset & ~stall;
   assign req_ready = grant & {NUM_REQ{open}};
   assign xfer      = win_any & open;
   assign win_req   = req_arr[win_idx];

`ifdef WB_PORT_ARBITER_X0_DROP_EN
   assign issue = xfer & (win_req.addr != '0);
`else
   assign issue = xfer;
`endif

   always_comb begin
      ptr_d     = ptr_q;
      wr_en_d   = issue;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      cnt_d     = cnt_q;
      if (xfer) begin
         ptr_d = PW'(rr_next(32'(win_idx), 32'(NUM_REQ)));
      end
      if (issue) begin
         wr_addr_d = win_req.addr;
         wr_data_d = win_req.data;
      end
      if (wr_en_q && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         cnt_q     <= '0;
      end else begin
         ptr_q     <= ptr_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         cnt_q     <= cnt_d;
      end
   end

   assign wr_en    = wr_en_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign wr_count = cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: tasks push expected writes, a monitor
// pops and compares them whenever the write port pulses.
module tb_wb_port_arbiter;

   localparam int NUM_REQ = 3;
   localparam int AW      = 5;
   localparam int XLEN    = 32;

   logic                    clk;
   logic                    reset;
   logic                    stall;
   logic [NUM_REQ-1:0]      req_valid;
   logic [NUM_REQ*AW-1:0]   req_addr;
   logic [NUM_REQ*XLEN-1:0] req_data;
   logic [NUM_REQ-1:0]      req_ready;
   logic                    wr_en;
   logic [AW-1:0]           wr_addr;
   logic [XLEN-1:0]         wr_data;
   logic [15:0]             wr_count;

   typedef struct {
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_cnt = 16'd0;

   wb_port_arbiter #(.NUM_REQ(NUM_REQ), .XLEN(XLEN), .AW(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .stall     (stall),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_ready (req_ready),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_count  (wr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every write-port pulse must match the oldest expected write.
   always @(negedge clk) begin
      if (reset === 1'b1 && wr_en === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", wr_addr, wr_data);
         end else begin
            mon_e = sb.pop_front();
            if (wr_addr !== mon_e.addr || wr_data !== mon_e.data) begin
               errors++;
               $display("FAIL write_data: got addr=%0d data=%h, expected addr=%0d data=%h",
                        wr_addr, wr_data, mon_e.addr, mon_e.data);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
      req_addr[i*AW +: AW]     = a;
      req_data[i*XLEN +: XLEN] = d;
   endtask

   task automatic push_exp(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
      exp_t e;
      e.addr = a;
      e.data = d;
      sb.push_back(e);
      if (exp_cnt != 16'hFFFF) exp_cnt++;
      $display("push write addr=%0d data=%h", a, d);
   endtask

   task automatic check_ready(input string name, input logic [NUM_REQ-1:0] exp);
      checks++;
      if (req_ready !== exp) begin
         errors++;
         $display("FAIL %s: req_ready=%b, expected %b", name, req_ready, exp);
      end
   endtask

   task automatic reset_pulse();
      @(posedge clk);
      #2 reset = 1'b0;
      #4 reset = 1'b1;
      exp_cnt = 16'd0;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b0; stall = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
      #3;
      req_valid = '1;
      #1;
      check_ready("reset_ready_low", 3'b000);
      tick();
      tick();
      checks++;
      if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0 || wr_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_state: wr_en=%b addr=%0d data=%h cnt=%0d, expected all zero",
                  wr_en, wr_addr, wr_data, wr_count);
      end
      check_ready("reset_ready_held", 3'b000);
      req_valid = '0;
      #2 reset = 1'b1;
      tick();
   endtask

   task automatic test_single();
      logic [XLEN-1:0] d;
      for (int k = 0; k < 4; k++) begin
         d = (k == 0) ? 32'h12345678 : 32'h1000 + XLEN'(k);
         set_req(0, 5'd3, d);
         req_valid = 3'b001;
         #1;
         check_ready("single_ready", 3'b001);
         push_exp(5'd3, d);
         tick();
         checks++;
         if (wr_en !== 1'b1 || wr_addr !== 5'd3 || wr_data !== d) begin
            errors++;
            $display("FAIL single_write: wr_en=%b addr=%0d data=%h, expected 1 3 %h", wr_en, wr_addr, wr_data, d);
         end
      end
      req_valid = '0;
      tick();
      checks++;
      if (wr_en !== 1'b0) begin
         errors++;
         $display("FAIL single_idle: wr_en=%b, expected 0", wr_en);
      end
   endtask

   task automatic test_reset_mid();
      set_req(0, 5'd4, 32'h77);
      req_valid = 3'b001;
      tick();
      set_req(1, 5'd6, 32'h66);
      req_valid = 3'b010;
      #1 reset = 1'b0;
      #1;
      checks++;
      if (wr_en !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_drop: wr_en=%b, expected 0", wr_en);
      end
      check_ready("reset_mid_ready", 3'b000);
      #20;
      reset = 1'b1;
      #1;
      checks++;
      if (wr_en !== 1'b0 || wr_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_mid_state: wr_en=%b cnt=%0d, expected 0 0", wr_en, wr_count);
      end
      check_ready("reset_mid_first_grant", 3'b010);
      exp_cnt = 16'd0;
      push_exp(5'd6, 32'h66);
      tick();
      req_valid = '0;
      tick();
   endtask

   task automatic test_rotation();
      logic [XLEN-1:0] dv [3];
      dv[0] = 32'hA0; dv[1] = 32'hB1; dv[2] = 32'hC2;
      reset_pulse();
      for (int i = 0; i < 3; i++) set_req(i, AW'(i + 1), dv[i]);
      req_valid = 3'b111;
      for (int k = 0; k < 6; k++) begin
         #1;
         check_ready("rotation_grant", 3'(1 << (k % 3)));
         push_exp(AW'(k % 3 + 1), dv[k % 3]);
         tick();
      end
      req_valid = '0;
      tick();
      tick();
      checks++;
      if (wr_count !== 16'd6) begin
         errors++;
         $display("FAIL rotation_count: wr_count=%0d, expected 6", wr_count);
      end
   endtask

   task automatic test_stall();
      set_req(2, 5'd7, 32'h55);
      stall = 1'b1;
      req_valid = 3'b100;
      for (int k = 0; k < 3; k++) begin
         #1;
         check_ready("stall_ready", 3'b000);
         tick();
         checks++;
         if (wr_en !== 1'b0) begin
            errors++;
            $display("FAIL stall_wr_en: wr_en=%b, expected 0", wr_en);
         end
      end
      stall = 1'b0;
      #1;
      check_ready("stall_release", 3'b100);
      push_exp(5'd7, 32'h55);
      tick();
      req_valid = '0;
      stall = 1'b1;
      req_valid = 3'b111;
      tick();
      check_ready("stall_all_valid", 3'b000);
      stall = 1'b0;
      #1;
      check_ready("stall_ptr_hold", 3'b001);
      push_exp(5'd1, 32'hA0);
      tick();
      req_valid = '0;
      tick();
   endtask

   task automatic test_back_to_back();
      set_req(0, 5'd10, 32'h100);
      set_req(1, 5'd11, 32'h111);
      req_valid = 3'b011;
      for (int k = 0; k < 4; k++) begin
         #1;
         check_ready("b2b_grant", (k % 2 == 0) ? 3'b010 : 3'b001);
         if (k % 2 == 0) push_exp(5'd11, 32'h111);
         else            push_exp(5'd10, 32'h100);
         tick();
         checks++;
         if (wr_en !== 1'b1) begin
            errors++;
            $display("FAIL b2b_wr_en: wr_en=%b, expected 1", wr_en);
         end
      end
      stall = 1'b1;
      #1;
      check_ready("b2b_stall_ready", 3'b000);
      checks++;
      if (wr_en !== 1'b1) begin
         errors++;
         $display("FAIL b2b_inflight: wr_en=%b, expected 1", wr_en);
      end
      tick();
      checks++;
      if (wr_en !== 1'b0) begin
         errors++;
         $display("FAIL b2b_stall_idle: wr_en=%b, expected 0", wr_en);
      end
      stall = 1'b0;
      req_valid = '0;
      tick();
   endtask

   task automatic test_x0();
      set_req(1, 5'd0, 32'hDEADBEEF);
      req_valid = 3'b010;
      #1;
      check_ready("x0_ready", 3'b010);
`ifndef WB_PORT_ARBITER_X0_DROP_EN
      push_exp(5'd0, 32'hDEADBEEF);
`endif
      tick();
      checks++;
`ifdef WB_PORT_ARBITER_X0_DROP_EN
      if (wr_en !== 1'b0) begin
         errors++;
         $display("FAIL x0_drop: wr_en=%b, expected 0", wr_en);
      end
`else
      if (wr_en !== 1'b1 || wr_addr !== 5'd0) begin
         errors++;
         $display("FAIL x0_issue: wr_en=%b addr=%0d, expected 1 0", wr_en, wr_addr);
      end
`endif
      req_valid = 3'b111;
      #1;
      check_ready("x0_ptr_advance", 3'b100);
      push_exp(5'd7, 32'h55);
      tick();
      req_valid = '0;
      tick();
      tick();
      checks++;
      if (wr_count !== exp_cnt) begin
         errors++;
         $display("FAIL x0_count: wr_count=%0d, expected %0d", wr_count, exp_cnt);
      end
   endtask

   task automatic test_saturation();
      reset_pulse();
      set_req(0, 5'd9, 32'h0);
      req_valid = 3'b001;
      #1;
      check_ready("sat_ready", 3'b001);
      for (int n = 0; n < 65540; n++) begin
         req_data[0 +: XLEN] = XLEN'(n);
         push_exp(5'd9, XLEN'(n));
         tick();
      end
      req_valid = '0;
      tick();
      tick();
      checks++;
      if (wr_count !== exp_cnt || exp_cnt !== 16'hFFFF) begin
         errors++;
         $display("FAIL saturation: wr_count=%h, expected %h", wr_count, 16'hFFFF);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_reset_mid();
      test_rotation();
      test_stall();
      test_back_to_back();
      test_x0();
      test_saturation();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d writes outstanding, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
